ex_md: RTL and testbench
========================

EX_MD -- requirements
Module: ex_md

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: aluop_i  in  8  operation code (EXE_*_OP from defines.v); alusel_i  in  3  result class (EXE_RES_*).
REQ-004 SHALL have ports: reg1_i, reg2_i  in  32 each  operands from decode; wd_i  in  5  destination register; wreg_i  in  1  write enable from decode.
REQ-005 SHALL have ports: flush_i  in  1  abort of the in-flight instruction.
REQ-006 SHALL have ports: wd_o  out  5, wreg_o  out  1, wdata_o  out  32  register write-back and forwarding result.
REQ-007 SHALL have ports: whilo_o  out  1, hi_o  out  32, lo_o  out  32  HI/LO write; stallreq_o  out  1  pipeline stall request.

Function
REQ-008 Non-divide results SHALL be combinational from inputs, zero added latency; wd_o=wd_i, wreg_o=wreg_i.
REQ-009 LOGIC: OR/AND/XOR = reg1_i op reg2_i; NOT = ~reg1_i.
REQ-010 SHIFT: SHL = reg1_i<<reg2_i[4:0]; SHR logical right; SAR arithmetic right, same amount.
REQ-011 MOV: wdata_o=reg1_i; MOVZ/MOVN: wdata_o=reg2_i (write gating already in wreg_i).
REQ-012 ARITHMETIC: ADD/SUB 32-bit modulo 2^32, no overflow flag.
REQ-013 MULT (signed) / MULTU (unsigned): 64-bit product, hi_o=[63:32], lo_o=[31:0], whilo_o=1, same cycle, no stall.
REQ-014 Unknown aluop or alusel NOP: wdata_o=0, whilo_o=0, stallreq_o=0.
REQ-015 DIV: signed restoring divider, FSM states IDLE, BUSY, DONE; quotient truncates toward zero, remainder takes dividend sign.
REQ-016 IDLE + aluop_i=DIV: stallreq_o=1; divisor!=0 -> latch |operands| and signs, counter=0, go BUSY; divisor==0 -> go DONE with quotient=32'hFFFFFFFF, remainder=reg1_i.
REQ-017 BUSY: one quotient bit per cycle, counter+1; after 32nd iteration (counter==31) go DONE; stallreq_o=1 throughout.
REQ-018 DONE: stallreq_o=0, whilo_o=1, lo_o=quotient, hi_o=remainder for exactly one cycle; next state IDLE.
REQ-019 Nonzero-divisor DIV SHALL hold stallreq_o high exactly 33 cycles; divide-by-zero exactly 1 cycle.
REQ-020 Operands SHALL be sampled only on IDLE->BUSY; input changes during BUSY have no effect.
REQ-021 flush_i=1 in any state: stallreq_o=0, whilo_o=0 that cycle, next state IDLE; result discarded.
REQ-022 Signed corner: 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0 (wrap).

Reset
REQ-023 rst=1 at clock edge: FSM to IDLE, counter and divider registers to 0; rst has priority over flush_i and DIV.
REQ-024 While rst=1 all outputs SHALL be 0 (wd_o=0, wreg_o=0, wdata_o=0, whilo_o=0, hi_o=lo_o=0, stallreq_o=0).
REQ-025 rst mid-division SHALL abandon the operation; no HI/LO write occurs.

Configuration
REQ-026 Macro EX_DIV_EN defined: divider FSM per REQ-015..022 present.
REQ-027 EX_DIV_EN undefined: no divider logic; DIV treated as NOP per REQ-014, stallreq_o constant 0.

Verification
REQ-028 OR 32'h0000FF00, 32'h00F0F0F0, wd_i=5, wreg_i=1 -> wdata_o=32'h00F0FFF0, wd_o=5, wreg_o=1 same cycle.
REQ-029 SAR 32'h80000010 by reg2_i=4 -> wdata_o=32'hF8000001; MULT 32'hFFFFFFFE x 3 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFA, whilo_o=1.
REQ-030 DIV -7/2 held -> stallreq_o high 33 cycles, then DONE cycle lo=32'hFFFFFFFD, hi=32'hFFFFFFFF, whilo_o=1.
REQ-031 DIV 100/0 -> stallreq_o 1 cycle, then lo=32'hFFFFFFFF, hi=100.
REQ-032 DIV 1000/7, flush_i pulse at BUSY cycle 10 -> stallreq_o low next cycle, no whilo_o pulse; new DIV 9/3 afterwards -> lo=3, hi=0.
REQ-033 rst at BUSY cycle 5 -> all outputs 0, FSM IDLE; build without EX_DIV_EN -> DIV gives stallreq_o=0, whilo_o=0.

Source files
------------

// File: rtl/ex_md.sv
// Execute stage: logic/shift/move/arith/multiply ALU plus an optional signed restoring divider.
// Define EX_DIV_EN to build the divider FSM; without it DIV decodes as a NOP.
module ex_md (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        flush_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stallreq_o
);

    // Operation codes (EXE_*_OP)
    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOT_OP   = 8'b0010_1000;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_MOV_OP   = 8'b0000_1001;
    localparam logic [7:0] EXE_MOVZ_OP  = 8'b0000_1010;
    localparam logic [7:0] EXE_MOVN_OP  = 8'b0000_1011;
    localparam logic [7:0] EXE_ADD_OP   = 8'b0010_0000;
    localparam logic [7:0] EXE_SUB_OP   = 8'b0010_0010;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;

    // Result classes (EXE_RES_*)
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_MOVE  = 3'b011;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;
    localparam logic [2:0] EXE_RES_MUL   = 3'b101;

    logic [31:0] alu_res;
    logic [63:0] mul_prod;
    logic        mul_en;

    logic        div_stall;
    logic        div_wr;
    logic [31:0] div_hi;
    logic [31:0] div_lo;

    always_comb begin
        alu_res  = '0;
        mul_prod = '0;
        mul_en   = 1'b0;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_OR_OP:  alu_res = reg1_i | reg2_i;
                    EXE_AND_OP: alu_res = reg1_i & reg2_i;
                    EXE_XOR_OP: alu_res = reg1_i ^ reg2_i;
                    EXE_NOT_OP: alu_res = ~reg1_i;
                    default:    alu_res = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL_OP: alu_res = reg1_i << reg2_i[4:0];
                    EXE_SRL_OP: alu_res = reg1_i >> reg2_i[4:0];
                    EXE_SRA_OP: alu_res = $signed(reg1_i) >>> reg2_i[4:0];
                    default:    alu_res = '0;
                endcase
            end
            EXE_RES_MOVE: begin
                case (aluop_i)
                    EXE_MOV_OP:                alu_res = reg1_i;
                    EXE_MOVZ_OP, EXE_MOVN_OP:  alu_res = reg2_i;
                    default:                   alu_res = '0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (aluop_i)
                    EXE_ADD_OP: alu_res = reg1_i + reg2_i;
                    EXE_SUB_OP: alu_res = reg1_i - reg2_i;
                    default:    alu_res = '0;
                endcase
            end
            EXE_RES_MUL: begin
                case (aluop_i)
                    // Low 64 bits of a product of sign-extended operands equal the signed product
                    EXE_MULT_OP: begin
                        mul_prod = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
                        mul_en   = 1'b1;
                    end
                    EXE_MULTU_OP: begin
                        mul_prod = {32'b0, reg1_i} * {32'b0, reg2_i};
                        mul_en   = 1'b1;
                    end
                    default: mul_en = 1'b0;
                endcase
            end
            default: alu_res = '0;
        endcase
    end

`ifdef EX_DIV_EN
    typedef enum logic [1:0] {StIdle, StBusy, StDone} div_state_e;

    div_state_e  div_state;
    logic [4:0]  div_cnt;
    logic [31:0] div_r;
    logic [31:0] div_q;
    logic [31:0] div_b;
    logic        neg_q;
    logic        neg_r;

    logic        is_div;
    logic [31:0] r_shift;
    logic [31:0] q_shift;
    logic [31:0] r_next;
    logic [31:0] q_next;

    assign is_div = (aluop_i == EXE_DIV_OP);

    // Remainder magnitude stays below the divisor (<= 2^31), so the shifted value fits 32 bits
    always_comb begin
        r_shift = {div_r[30:0], div_q[31]};
        q_shift = {div_q[30:0], 1'b0};
        r_next  = r_shift;
        q_next  = q_shift;
        if (r_shift >= div_b) begin
            r_next = r_shift - div_b;
            q_next = q_shift | 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_state <= StIdle;
            div_cnt   <= '0;
            div_r     <= '0;
            div_q     <= '0;
            div_b     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else if (flush_i) begin
            div_state <= StIdle;
            div_cnt   <= '0;
        end else begin
            case (div_state)
                StIdle: begin
                    if (is_div) begin
                        div_cnt <= '0;
                        if (reg2_i != 32'd0) begin
                            div_q     <= reg1_i[31] ? -reg1_i : reg1_i;
                            div_b     <= reg2_i[31] ? -reg2_i : reg2_i;
                            div_r     <= '0;
                            neg_q     <= reg1_i[31] ^ reg2_i[31];
                            neg_r     <= reg1_i[31];
                            div_state <= StBusy;
                        end else begin
                            div_q     <= 32'hFFFF_FFFF;
                            div_r     <= reg1_i;
                            neg_q     <= 1'b0;
                            neg_r     <= 1'b0;
                            div_state <= StDone;
                        end
                    end
                end
                StBusy: begin
                    div_r   <= r_next;
                    div_q   <= q_next;
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'd31) begin
                        div_state <= StDone;
                    end
                end
                StDone:  div_state <= StIdle;
                default: div_state <= StIdle;
            endcase
        end
    end

    assign div_stall = !flush_i && ((div_state == StIdle && is_div) || div_state == StBusy);
    assign div_wr    = !flush_i && (div_state == StDone);
    assign div_lo    = neg_q ? -div_q : div_q;
    assign div_hi    = neg_r ? -div_r : div_r;
`else
    logic unused_clk;

    assign unused_clk = clk;
    assign div_stall  = 1'b0;
    assign div_wr     = 1'b0;
    assign div_lo     = '0;
    assign div_hi     = '0;
`endif

    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i;
            wdata_o    = alu_res;
            stallreq_o = div_stall;
            if (div_wr) begin
                whilo_o = 1'b1;
                hi_o    = div_hi;
                lo_o    = div_lo;
            end else if (mul_en && !flush_i) begin
                whilo_o = 1'b1;
                hi_o    = mul_prod[63:32];
                lo_o    = mul_prod[31:0];
            end
        end
    end

endmodule

// File: tb/tb_ex_md.sv
// Randomized self-checking bench for ex_md against a behavioural model.
// Divider scenarios run only when EX_DIV_EN is defined; otherwise DIV must act as a NOP.
module tb_ex_md;

    localparam logic [7:0] OP_NOP   = 8'b0000_0000;
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOT   = 8'b0010_1000;
    localparam logic [7:0] OP_SLL   = 8'b0111_1100;
    localparam logic [7:0] OP_SRL   = 8'b0000_0010;
    localparam logic [7:0] OP_SRA   = 8'b0000_0011;
    localparam logic [7:0] OP_MOV   = 8'b0000_1001;
    localparam logic [7:0] OP_MOVZ  = 8'b0000_1010;
    localparam logic [7:0] OP_MOVN  = 8'b0000_1011;
    localparam logic [7:0] OP_ADD   = 8'b0010_0000;
    localparam logic [7:0] OP_SUB   = 8'b0010_0010;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_MOVE  = 3'b011;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_MUL   = 3'b101;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i, flush_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stallreq_o;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    ex_md dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .flush_i    (flush_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Advance to just after the next rising edge; inputs are driven here, outputs sampled #2 later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wreg);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = wd;
        wreg_i   = wreg;
    endtask

    // Reference model of the single-cycle operations
    function automatic void model_alu(input logic [7:0] op, input logic [2:0] sel,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] wdata, output logic whilo,
                                      output logic [63:0] hilo);
        int unsigned s;
        logic [31:0] ones;
        longint      sa, sb;
        s     = b[4:0];
        ones  = 32'hFFFF_FFFF;
        wdata = '0;
        whilo = 1'b0;
        hilo  = '0;
        if (sel == SEL_LOGIC && op == OP_OR)  wdata = a | b;
        if (sel == SEL_LOGIC && op == OP_AND) wdata = a & b;
        if (sel == SEL_LOGIC && op == OP_XOR) wdata = a ^ b;
        if (sel == SEL_LOGIC && op == OP_NOT) wdata = ~a;
        if (sel == SEL_SHIFT && op == OP_SLL) wdata = a << s;
        if (sel == SEL_SHIFT && op == OP_SRL) wdata = a >> s;
        if (sel == SEL_SHIFT && op == OP_SRA) wdata = (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
        if (sel == SEL_MOVE && op == OP_MOV)  wdata = a;
        if (sel == SEL_MOVE && (op == OP_MOVZ || op == OP_MOVN)) wdata = b;
        if (sel == SEL_ARITH && op == OP_ADD) wdata = a + b;
        if (sel == SEL_ARITH && op == OP_SUB) wdata = a - b;
        if (sel == SEL_MUL && op == OP_MULT) begin
            sa    = longint'($signed(a));
            sb    = longint'($signed(b));
            hilo  = 64'(sa * sb);
            whilo = 1'b1;
        end
        if (sel == SEL_MUL && op == OP_MULTU) begin
            hilo  = {32'd0, a} * {32'd0, b};
            whilo = 1'b1;
        end
    endfunction

    task automatic check_all(input string tag, input logic [31:0] e_wdata, input logic [4:0] e_wd,
                             input logic e_wreg, input logic e_whilo, input logic [63:0] e_hilo,
                             input logic e_stall);
        check({tag, ".wdata"}, 64'(wdata_o), 64'(e_wdata));
        check({tag, ".wd"}, 64'(wd_o), 64'(e_wd));
        check({tag, ".wreg"}, 64'(wreg_o), 64'(e_wreg));
        check({tag, ".whilo"}, 64'(whilo_o), 64'(e_whilo));
        check({tag, ".hilo"}, {hi_o, lo_o}, e_hilo);
        check({tag, ".stall"}, 64'(stallreq_o), 64'(e_stall));
    endtask

`ifdef EX_DIV_EN
    // Issue a DIV and hold it until the result cycle; optionally scramble operands mid-flight
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit scramble);
        longint      la, lb;
        logic [31:0] eq, er;
        int          exp_stall, n;
        if (b == 32'd0) begin
            eq        = 32'hFFFF_FFFF;
            er        = a;
            exp_stall = 1;
        end else begin
            la        = longint'($signed(a));
            lb        = longint'($signed(b));
            eq        = 32'(la / lb);
            er        = 32'(la % lb);
            exp_stall = 33;
        end
        cyc();
        drive(OP_DIV, SEL_NOP, a, b, 5'd0, 1'b0);
        #2;
        n = 0;
        while (stallreq_o === 1'b1 && n < 100) begin
            n++;
            cyc();
            if (scramble && n == 2) begin
                reg1_i = $urandom;
                reg2_i = $urandom;
            end
            #2;
        end
        check({tag, ".stall_cycles"}, 64'(n), 64'(exp_stall));
        check({tag, ".whilo"}, 64'(whilo_o), 64'd1);
        check({tag, ".lo"}, 64'(lo_o), 64'(eq));
        check({tag, ".hi"}, 64'(hi_o), 64'(er));
        cyc();
        drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        #2;
        check({tag, ".after_whilo"}, 64'(whilo_o), 64'd0);
    endtask
`endif

    logic [7:0]  op_tab  [15] = '{OP_OR, OP_AND, OP_XOR, OP_NOT, OP_SLL, OP_SRL, OP_SRA, OP_MOV,
                                  OP_MOVZ, OP_MOVN, OP_ADD, OP_SUB, OP_MULT, OP_MULTU, OP_NOP};
    logic [2:0]  sel_tab [15] = '{SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_LOGIC, SEL_SHIFT, SEL_SHIFT,
                                  SEL_SHIFT, SEL_MOVE, SEL_MOVE, SEL_MOVE, SEL_ARITH, SEL_ARITH,
                                  SEL_MUL, SEL_MUL, SEL_NOP};

    initial begin
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a, b, e_wdata;
        logic [4:0]  wd;
        logic        wreg, e_whilo;
        logic [63:0] e_hilo;
        int          k;

        rst     = 1'b1;
        flush_i = 1'b0;
        drive(OP_OR, SEL_LOGIC, 32'h1234_5678, 32'h0F0F_0F0F, 5'd9, 1'b1);
        cyc();
        #2;
        check_all("reset", 32'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        cyc();
        drive(OP_MULT, SEL_MUL, 32'd7, 32'd9, 5'd3, 1'b1);
        #2;
        check_all("reset_mult", 32'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        cyc();
        rst = 1'b0;

        drive(OP_OR, SEL_LOGIC, 32'h0000_FF00, 32'h00F0_F0F0, 5'd5, 1'b1);
        #2;
        check_all("or_vec", 32'h00F0_FFF0, 5'd5, 1'b1, 1'b0, 64'd0, 1'b0);
        cyc();
        drive(OP_SRA, SEL_SHIFT, 32'h8000_0010, 32'd4, 5'd1, 1'b1);
        #2;
        check_all("sar_vec", 32'hF800_0001, 5'd1, 1'b1, 1'b0, 64'd0, 1'b0);
        cyc();
        drive(OP_MULT, SEL_MUL, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b0);
        #2;
        check_all("mult_vec", 32'd0, 5'd0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);

        for (int i = 0; i < 200; i++) begin
            cyc();
            k   = int'($urandom_range(0, 14));
            op  = op_tab[k];
            sel = sel_tab[k];
            if ($urandom_range(0, 9) == 0) begin
                op  = 8'($urandom);
                sel = 3'($urandom);
                if (op == OP_DIV) op = OP_NOP;
            end
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
            wd   = 5'($urandom);
            wreg = 1'($urandom);
            drive(op, sel, a, b, wd, wreg);
            #2;
            model_alu(op, sel, a, b, e_wdata, e_whilo, e_hilo);
            check_all($sformatf("rand%0d", i), e_wdata, wd, wreg, e_whilo, e_hilo, 1'b0);
        end

`ifdef EX_DIV_EN
        run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_div("div_100_0", 32'd100, 32'd0, 1'b0);
        run_div("div_corner", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < 4; i++) begin
            run_div($sformatf("div_rand%0d", i), $urandom, $urandom | 32'd1, 1'b1);
        end

        // Flush at the 10th BUSY cycle
        cyc();
        drive(OP_DIV, SEL_NOP, 32'd1000, 32'd7, 5'd0, 1'b0);
        k = 0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            #2;
            if (stallreq_o === 1'b1) k++;
        end
        check("flush.busy_stall", 64'(k), 64'd9);
        cyc();
        flush_i = 1'b1;
        #2;
        check("flush.stall", 64'(stallreq_o), 64'd0);
        check("flush.whilo", 64'(whilo_o), 64'd0);
        cyc();
        flush_i = 1'b0;
        drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) k++;
            cyc();
        end
        check("flush.quiet", 64'(k), 64'd0);
        run_div("div_9_3", 32'd9, 32'd3, 1'b0);

        // Reset at the 5th BUSY cycle
        cyc();
        drive(OP_DIV, SEL_NOP, 32'hFFFF_FF9C, 32'd3, 5'd4, 1'b1);
        for (int i = 0; i < 5; i++) cyc();
        rst = 1'b1;
        #2;
        check_all("rst_busy", 32'd0, 5'd0, 1'b0, 1'b0, 64'd0, 1'b0);
        cyc();
        rst = 1'b0;
        drive(OP_NOP, SEL_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
        k = 0;
        for (int i = 0; i < 40; i++) begin
            #2;
            if (stallreq_o !== 1'b0 || whilo_o !== 1'b0) k++;
            cyc();
        end
        check("rst_busy.quiet", 64'(k), 64'd0);
        run_div("div_after_rst", 32'hFFFF_FF9C, 32'd3, 1'b0);
`else
        for (int i = 0; i < 3; i++) begin
            cyc();
            drive(OP_DIV, SEL_NOP, $urandom, $urandom, 5'd2, 1'b0);
            #2;
            check_all($sformatf("div_nop%0d", i), 32'd0, 5'd2, 1'b0, 1'b0, 64'd0, 1'b0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
